// File: rtl/systolic_drain.sv
// systolic_drain: read side of the dense systolic array's accumulator output.
// Snapshots the flat accumulator bus when a tile completes, pulses arr_clr back
// to the array, then streams the snapshot row by row (BPR beats per row) over a
// valid/ready interface.
// Optional feature macro: DRAIN_REQUANT_EN adds requant_shift[4:0] and turns each
// output lane into a rounded, arithmetically shifted, int8-saturated value.
module systolic_drain #(
    parameter int N_ROWS = 14,
    parameter int N_COLS = 14,
    parameter int LANES  = 14
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_ROWS*N_COLS*32-1:0]   c_in_flat,
    input  logic                          drain_start,
`ifdef DRAIN_REQUANT_EN
    input  logic [4:0]                    requant_shift,
`endif
    output logic                          arr_clr,
    output logic                          drain_busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES*32-1:0]           out_data,
    output logic [$clog2(N_ROWS)-1:0]     out_row,
    output logic                          out_last,
    output logic                          drain_done
);

    localparam int BPR    = N_COLS / LANES;
    localparam int NBEATS = N_ROWS * BPR;
    localparam int BEAT_W = LANES * 32;
    localparam int RW     = $clog2(N_ROWS);
    localparam int BW     = (BPR > 1) ? $clog2(BPR) : 1;
    localparam int IW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [RW-1:0] ROW_LAST  = RW'(N_ROWS - 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BPR - 1);

    // A row must split into whole beats.
    if (N_COLS % LANES != 0) begin : g_bad_lanes
        $error("systolic_drain: N_COLS must be a multiple of LANES");
    end

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_nx;
    logic [RW-1:0]   row_q;
    logic [BW-1:0]   beat_q;
    logic [IW-1:0]   idx_q;
    logic            clr_q;
    logic            capture;
    logic            accept;
    logic            vld_p0;
    logic            last_beat;
    logic [BEAT_W-1:0] beat_raw;

    // Snapshot stored one output beat per entry, in streaming order.
    logic [BEAT_W-1:0] snap_p0 [NBEATS];

`ifdef DRAIN_REQUANT_EN
    logic [4:0] shift_p0;

    // Round-half-up arithmetic shift, saturate to int8, sign-extend to 32b.
    function automatic logic [31:0] requant(input logic signed [31:0] acc,
                                            input logic [4:0]         sh);
        logic signed [32:0] ext;
        logic signed [32:0] rnd;
        logic signed [32:0] shf;
        ext = {acc[31], acc};
        rnd = (sh == 5'd0) ? 33'sd0 : (33'sd1 <<< (sh - 5'd1));
        shf = (ext + rnd) >>> sh;
        if (shf > 33'sd127)
            return 32'h0000_007f;
        else if (shf < -33'sd128)
            return 32'hffff_ff80;
        else
            return {{24{shf[7]}}, shf[7:0]};
    endfunction
`endif

    // Next-state and handshake decode; a start outside IDLE is ignored.
    always_comb begin
        state_nx   = state_q;
        capture    = 1'b0;
        accept     = 1'b0;
        vld_p0     = 1'b0;
        drain_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (drain_start) begin
                    capture  = 1'b1;
                    state_nx = S_STREAM;
                end
            end
            S_STREAM: begin
                vld_p0 = 1'b1;
                if (out_ready) begin
                    accept = 1'b1;
                    if (last_beat) state_nx = S_DONE;
                end
            end
            S_DONE: begin
                drain_done = 1'b1;
                state_nx   = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign last_beat  = (row_q == ROW_LAST) && (beat_q == BEAT_LAST);
    assign out_valid  = vld_p0;
    assign out_last   = vld_p0 && last_beat;
    assign drain_busy = (state_q != S_IDLE);
    assign arr_clr    = clr_q;
    assign out_row    = row_q;

    // State, row/beat counters and the clear pulse; counters only move on a handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            row_q   <= '0;
            beat_q  <= '0;
            idx_q   <= '0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_nx;
            clr_q   <= capture;
            if (capture) begin
                row_q  <= '0;
                beat_q <= '0;
                idx_q  <= '0;
            end else if (accept && !last_beat) begin
                idx_q <= idx_q + 1'b1;
                if (beat_q == BEAT_LAST) begin
                    beat_q <= '0;
                    row_q  <= row_q + 1'b1;
                end else begin
                    beat_q <= beat_q + 1'b1;
                end
            end
        end
    end

    // ---- p0: snapshot capture (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < NBEATS; k++) begin
                snap_p0[k] <= c_in_flat[k*BEAT_W +: BEAT_W];
            end
`ifdef DRAIN_REQUANT_EN
            shift_p0 <= requant_shift;
`endif
        end
    end

    // ---- output: beat select and optional requant, zero while not valid ----
    always_comb begin
        beat_raw = snap_p0[idx_q];
        out_data = '0;
        if (vld_p0) begin
`ifdef DRAIN_REQUANT_EN
            for (int l = 0; l < LANES; l++) begin
                out_data[l*32 +: 32] = requant(beat_raw[l*32 +: 32], shift_p0);
            end
`else
            out_data = beat_raw;
`endif
        end
    end

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain (4x4 array, 2 lanes, 2 beats per row).
// Expected beats are derived from a per-PE value table captured at start time.
module tb_systolic_drain;

    localparam int NR  = 4;
    localparam int NC  = 4;
    localparam int LN  = 2;
    localparam int BPR = NC / LN;
    localparam int NB  = NR * BPR;
    localparam int DW  = LN * 32;
    localparam int FW  = NR * NC * 32;
    localparam int RW  = $clog2(NR);

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] c_in_flat;
    logic          drain_start;
    logic          arr_clr;
    logic          drain_busy;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_row;
    logic          out_last;
    logic          drain_done;
`ifdef DRAIN_REQUANT_EN
    logic [4:0]    requant_shift;
`endif

    systolic_drain #(.N_ROWS(NR), .N_COLS(NC), .LANES(LN)) dut (
        .clk         (clk),
        .rst         (rst),
        .c_in_flat   (c_in_flat),
        .drain_start (drain_start),
`ifdef DRAIN_REQUANT_EN
        .requant_shift(requant_shift),
`endif
        .arr_clr     (arr_clr),
        .drain_busy  (drain_busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .drain_done  (drain_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference: PE values as they were when the tile was started.
    logic [31:0] pe [NR][NC];
    int          qshift = 0;

    // Observations gathered by collect().
    logic [DW-1:0] got_data [$];
    int            got_row  [$];
    logic          got_last [$];
    int clr_cnt, done_cnt, done_cyc, unstable, timeout;
    logic busy_end;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_tile(input int pattern);
        for (int r = 0; r < NR; r++)
            for (int c = 0; c < NC; c++)
                pe[r][c] = (pattern == 0) ? 32'(r * 16 + c) : $urandom;
    endtask

    task automatic drive_flat();
        c_in_flat = '0;
        for (int r = NR - 1; r >= 0; r--)
            for (int c = NC - 1; c >= 0; c--)
                c_in_flat = {c_in_flat[FW-33:0], pe[r][c]};
    endtask

    function automatic logic [31:0] lane_val(input logic [31:0] w);
`ifdef DRAIN_REQUANT_EN
        longint a;
        a = longint'(signed'(w));
        if (qshift != 0) a = a + (longint'(1) << (qshift - 1));
        a = a >>> qshift;
        if (a > 127) a = 127;
        if (a < -128) a = -128;
        return 32'(a);
`else
        return w;
`endif
    endfunction

    function automatic logic [DW-1:0] exp_beat(input int k);
        logic [DW-1:0] v = '0;
        int r = k / BPR;
        int b = k % BPR;
        for (int l = LN - 1; l >= 0; l--)
            v = {v[DW-33:0], lane_val(pe[r][b*LN + l])};
        return v;
    endfunction

    // Starts a tile; returns at the sample point of the cycle after capture.
    task automatic pulse_start();
`ifdef DRAIN_REQUANT_EN
        requant_shift = 5'(qshift);
`endif
        drive_flat();
        drain_start = 1'b1;
        step();
        drain_start = 1'b0;
    endtask

    // Drives out_ready (0: always, 1: 1,0,0,1 pattern, 2: random) and records
    // accepted beats until two cycles after drain_done; optional start at inject_at.
    task automatic collect(input int mode, input int inject_at);
        logic          stalled = 1'b0;
        logic [DW-1:0] s_data  = '0;
        logic [RW-1:0] s_row   = '0;
        logic          s_last  = 1'b0;
        logic          rdy;
        int            cyc = 0;
        got_data.delete(); got_row.delete(); got_last.delete();
        clr_cnt = 0; done_cnt = 0; done_cyc = -1; unstable = 0; timeout = 0;
        busy_end = 1'b0;
        forever begin
            if (cyc > 300) begin
                timeout = 1;
                break;
            end
            if (arr_clr) clr_cnt++;
            if (drain_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (stalled && (!out_valid || out_data !== s_data || out_row !== s_row ||
                            out_last !== s_last)) unstable++;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready   = rdy;
            drain_start = (cyc == inject_at);
            if (out_valid && rdy) begin
                got_data.push_back(out_data);
                got_row.push_back(int'(out_row));
                got_last.push_back(out_last);
                stalled = 1'b0;
            end else if (out_valid) begin
                stalled = 1'b1;
                s_data = out_data; s_row = out_row; s_last = out_last;
            end else begin
                stalled = 1'b0;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
                busy_end = drain_busy;
                break;
            end
            step();
            cyc++;
        end
        out_ready   = 1'b0;
        drain_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; drain_start = 1'b0; out_ready = 1'b0; c_in_flat = '0;
`ifdef DRAIN_REQUANT_EN
        requant_shift = '0;
`endif
        step(); step(); step();
        n_cmp++; if (arr_clr !== 1'b0)    begin n_bad++; $display("FAIL reset_arr_clr got=%b want=0", arr_clr); end
        n_cmp++; if (drain_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", drain_busy); end
        n_cmp++; if (out_valid !== 1'b0)  begin n_bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
        n_cmp++; if (out_last !== 1'b0)   begin n_bad++; $display("FAIL reset_last got=%b want=0", out_last); end
        n_cmp++; if (drain_done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", drain_done); end
        n_cmp++; if (out_data !== '0)     begin n_bad++; $display("FAIL reset_data got=%h want=0", out_data); end
        n_cmp++; if (out_row !== '0)      begin n_bad++; $display("FAIL reset_row got=%0d want=0", out_row); end
        rst = 1'b0;
        step(); step();
        n_cmp++; if (out_valid !== 1'b0 || drain_busy !== 1'b0)
            begin n_bad++; $display("FAIL idle_quiet valid=%b busy=%b want 0/0", out_valid, drain_busy); end
    endtask

    // Full-rate, patterned-stall and random-stall drains.
    task automatic test_stream();
        for (int mode = 0; mode < 3; mode++) begin
            load_tile(mode == 0 ? 0 : 1);
            pulse_start();
            n_cmp++; if (arr_clr !== 1'b1 || out_valid !== 1'b1 || drain_busy !== 1'b1)
                begin n_bad++; $display("FAIL first_cycle mode=%0d clr=%b valid=%b busy=%b want 1/1/1", mode, arr_clr, out_valid, drain_busy); end
            collect(mode, -1);
            n_cmp++; if (timeout != 0) begin n_bad++; $display("FAIL stream_timeout mode=%0d got=1 want=0", mode); end
            n_cmp++; if (got_data.size() != NB) begin n_bad++; $display("FAIL beat_count mode=%0d got=%0d want=%0d", mode, got_data.size(), NB); end
            for (int k = 0; k < NB && k < got_data.size(); k++) begin
                n_cmp++; if (got_data[k] !== exp_beat(k) || got_row[k] != k / BPR || got_last[k] !== (k == NB - 1))
                    begin n_bad++; $display("FAIL beat mode=%0d k=%0d got=%h/r%0d/l%b want=%h/r%0d/l%b", mode, k, got_data[k], got_row[k], got_last[k], exp_beat(k), k / BPR, k == NB - 1); end
            end
            n_cmp++; if (clr_cnt != 1 || done_cnt != 1 || unstable != 0 || busy_end !== 1'b0)
                begin n_bad++; $display("FAIL stream_ctl mode=%0d clr=%0d done=%0d unstable=%0d busy_end=%b want 1/1/0/0", mode, clr_cnt, done_cnt, unstable, busy_end); end
            if (mode == 0) begin
                n_cmp++; if (done_cyc != NB) begin n_bad++; $display("FAIL throughput done_cyc got=%0d want=%0d", done_cyc, NB); end
            end
        end
    endtask

    task automatic test_snapshot_isolation();
        load_tile(1);
        pulse_start();
        c_in_flat = {(FW/32){32'hDEADBEEF}};
        collect(2, -1);
        n_cmp++; if (got_data.size() != NB) begin n_bad++; $display("FAIL iso_count got=%0d want=%0d", got_data.size(), NB); end
        for (int k = 0; k < NB && k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_beat(k))
                begin n_bad++; $display("FAIL iso_beat k=%0d got=%h want=%h", k, got_data[k], exp_beat(k)); end
        end
    endtask

    task automatic test_ignored_start();
        load_tile(1);
        pulse_start();
        collect(0, 3);
        n_cmp++; if (clr_cnt != 1 || got_data.size() != NB || done_cnt != 1)
            begin n_bad++; $display("FAIL mid_start clr=%0d beats=%0d done=%0d want 1/%0d/1", clr_cnt, got_data.size(), done_cnt, NB); end
        n_cmp++; if (got_data.size() == NB && got_data[NB-1] !== exp_beat(NB - 1))
            begin n_bad++; $display("FAIL mid_start_data got=%h want=%h", got_data[NB-1], exp_beat(NB - 1)); end
        load_tile(1);
        pulse_start();
        collect(0, NB);
        n_cmp++; if (clr_cnt != 1 || busy_end !== 1'b0)
            begin n_bad++; $display("FAIL done_start clr=%0d busy_end=%b want 1/0", clr_cnt, busy_end); end
        load_tile(1);
        pulse_start();
        collect(1, -1);
        n_cmp++; if (clr_cnt != 1 || got_data.size() != NB || done_cnt != 1)
            begin n_bad++; $display("FAIL restart clr=%0d beats=%0d done=%0d want 1/%0d/1", clr_cnt, got_data.size(), done_cnt, NB); end
        for (int k = 0; k < NB && k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_beat(k))
                begin n_bad++; $display("FAIL restart_beat k=%0d got=%h want=%h", k, got_data[k], exp_beat(k)); end
        end
    endtask

    task automatic test_reset_mid();
        int dones = 0;
        load_tile(0);
        pulse_start();
        out_ready = 1'b1;
        step();
        n_cmp++; if (out_valid !== 1'b1 || out_data !== exp_beat(1))
            begin n_bad++; $display("FAIL pre_rst_beat valid=%b got=%h want=%h", out_valid, out_data, exp_beat(1)); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (out_valid !== 1'b0 || drain_busy !== 1'b0 || drain_done !== 1'b0 || out_row !== '0)
            begin n_bad++; $display("FAIL mid_rst valid=%b busy=%b done=%b row=%0d want 0/0/0/0", out_valid, drain_busy, drain_done, out_row); end
        for (int i = 0; i < 4; i++) begin
            if (drain_done) dones++;
            step();
        end
        n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL rst_partial_done got=%0d want=0", dones); end
        load_tile(1);
        pulse_start();
        collect(2, -1);
        n_cmp++; if (got_data.size() != NB || done_cnt != 1 || clr_cnt != 1)
            begin n_bad++; $display("FAIL post_rst beats=%0d done=%0d clr=%0d want %0d/1/1", got_data.size(), done_cnt, clr_cnt, NB); end
        for (int k = 0; k < NB && k < got_data.size(); k++) begin
            n_cmp++; if (got_data[k] !== exp_beat(k))
                begin n_bad++; $display("FAIL post_rst_beat k=%0d got=%h want=%h", k, got_data[k], exp_beat(k)); end
        end
    endtask

    task automatic test_requant();
        logic [DW-1:0] want0;
        logic [DW-1:0] want1;
        load_tile(1);
        pe[0][0] = 32'd1000;
        pe[0][1] = -32'sd1000;
        pe[0][2] = 32'd24;
        pe[0][3] = -32'sd8;
        qshift = 4;
`ifdef DRAIN_REQUANT_EN
        want0 = {32'hFFFF_FFC2, 32'h0000_003F};
        want1 = {32'h0000_0000, 32'h0000_0002};
`else
        want0 = {32'hFFFF_FC18, 32'h0000_03E8};
        want1 = {32'hFFFF_FFF8, 32'h0000_0018};
`endif
        pulse_start();
        collect(0, -1);
        n_cmp++; if (got_data.size() != NB) begin n_bad++; $display("FAIL rq_count got=%0d want=%0d", got_data.size(), NB); end
        if (got_data.size() == NB) begin
            n_cmp++; if (got_data[0] !== want0) begin n_bad++; $display("FAIL rq_beat0 got=%h want=%h", got_data[0], want0); end
            n_cmp++; if (got_data[1] !== want1) begin n_bad++; $display("FAIL rq_beat1 got=%h want=%h", got_data[1], want1); end
            for (int k = 2; k < NB; k++) begin
                n_cmp++; if (got_data[k] !== exp_beat(k))
                    begin n_bad++; $display("FAIL rq_beat k=%0d got=%h want=%h", k, got_data[k], exp_beat(k)); end
            end
        end
        qshift = 0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_snapshot_isolation();
        test_ignored_start();
        test_reset_mid();
        test_requant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
